// File: rtl/pll_reset_seq_if.sv
// pll_reset_seq_if -- signal bundle between the PLL reset sequencer and its
// surroundings (PLL macro, core reset distribution, status logic).
//
// Signals:
//   pll_locked  PLL lock indication, asynchronous to refclk
//   relock_req  single-cycle request to re-sequence the PLL (refclk domain)
//   pll_rst     active-high reset into the PLL
//   core_reset  active-high reset for the core clock domains
//   ready       core clocks valid and released
//   fail        lock retries exhausted
//   retry_cnt   timeouts since the last successful lock
//   lost_cnt    lock losses seen while running, saturating at 255
//
// Modports:
//   master  environment side: drives pll_locked/relock_req, observes status
//   slave   sequencer side: observes pll_locked/relock_req, drives status
interface pll_reset_seq_if;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       core_reset;
  logic       ready;
  logic       fail;
  logic [7:0] retry_cnt;
  logic [7:0] lost_cnt;

  modport master (
    output pll_locked, relock_req,
    input  pll_rst, core_reset, ready, fail, retry_cnt, lost_cnt
  );

  modport slave (
    input  pll_locked, relock_req,
    output pll_rst, core_reset, ready, fail, retry_cnt, lost_cnt
  );
endinterface

// File: rtl/pll_reset_seq.sv
// pll_reset_seq -- PLL reset / lock supervision sequencer.
//
// Pulses the PLL reset, waits for lock with a timeout, filters the lock
// indication for LOCK_FILTER consecutive cycles, then releases the core
// reset. Lock loss while running, or a relock request, restarts the
// sequence. After MAX_RETRY consecutive lock timeouts it parks in FAIL
// until a relock request arrives.
//
// Ports:
//   refclk  sole clock (PLL reference), rising edge
//   rst_n   asynchronous active-low reset; released through a 2-flop
//           synchronizer so the sequencer leaves reset cleanly on refclk
//   bus     pll_reset_seq_if.slave: pll_locked, relock_req in;
//           pll_rst, core_reset, ready, fail, retry_cnt, lost_cnt out
module pll_reset_seq #(
  parameter int RST_CYCLES  = 16,
  parameter int LOCK_FILTER = 1024,
  parameter int TIMEOUT     = 65535,
  parameter int MAX_RETRY   = 3
) (
  input  logic            refclk,
  input  logic            rst_n,
  pll_reset_seq_if.slave  bus
);

  // The shared counter must hold the longest per-state span without wrapping.
  localparam int MAX_AB   = (RST_CYCLES > LOCK_FILTER) ? RST_CYCLES : LOCK_FILTER;
  localparam int MAX_SPAN = (MAX_AB > TIMEOUT) ? MAX_AB : TIMEOUT;
  localparam int CNT_W    = $clog2(MAX_SPAN + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    FILTER,
    RUN,
    FAIL
  } state_t;

  logic [1:0]       rst_sync_q;
  logic [1:0]       lock_sync_q;
  logic             run_en;
  logic             lock_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic [7:0]       lost_q, lost_d;
  logic             restart;

  logic             pll_rst_q, core_reset_q, ready_q, fail_q;

  // Reset release synchronizer: assertion is immediate through the async
  // clear, release happens two refclk edges after rst_n rises.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run_en = rst_sync_q[1];

  // pll_locked comes from the PLL's own timing domain; two flops bring it
  // into refclk before any decision is made on it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], bus.pll_locked};
    end
  end

  assign lock_s = lock_sync_q[1];

  // Next-state logic. A relock request in the pre-run states keeps (or
  // returns to) RESET_PLL; 'restart' clears the counter even when the state
  // itself does not change.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    restart = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      RESET_PLL: begin
        if (bus.relock_req) begin
          restart = 1'b1;
        end else if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
        end
      end

      WAIT_LOCK: begin
        if (bus.relock_req) begin
          state_d = RESET_PLL;
        end else if (lock_s) begin
          state_d = FILTER;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_q + 8'd1;
          state_d = (retry_d == RETRY_LIMIT) ? FAIL : RESET_PLL;
        end
      end

      FILTER: begin
        if (bus.relock_req) begin
          state_d = RESET_PLL;
        end else if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == FILTER_LAST) begin
          state_d = RUN;
          retry_d = 8'd0;
        end
      end

      RUN: begin
        // Lock loss takes precedence so a simultaneous relock request still
        // records the loss.
        if (!lock_s) begin
          state_d = RESET_PLL;
          if (lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
          end
        end else if (bus.relock_req) begin
          state_d = RESET_PLL;
        end
      end

      FAIL: begin
        if (bus.relock_req) begin
          state_d = RESET_PLL;
          retry_d = 8'd0;
        end
      end

      default: begin
        state_d = RESET_PLL;
      end
    endcase

    // Counter restarts on every state change and saturates otherwise, so
    // the long-lived states (RUN, FAIL) never wrap it.
    if ((state_d != state_q) || restart) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, counters and output registers. Outputs are decoded from the next
  // state so they switch on the same edge as the state register, glitch
  // free. While the reset synchronizer is still releasing, everything is
  // held at its reset value.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= 8'd0;
      lost_q       <= 8'd0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else if (!run_en) begin
      state_q      <= RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= 8'd0;
      lost_q       <= 8'd0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      lost_q       <= lost_d;
      pll_rst_q    <= (state_d == RESET_PLL);
      core_reset_q <= (state_d != RUN);
      ready_q      <= (state_d == RUN);
      fail_q       <= (state_d == FAIL);
    end
  end

  assign bus.pll_rst    = pll_rst_q;
  assign bus.core_reset = core_reset_q;
  assign bus.ready      = ready_q;
  assign bus.fail       = fail_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.lost_cnt   = lost_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq -- directed, table-driven bench for pll_reset_seq with
// RST_CYCLES=4, LOCK_FILTER=8, TIMEOUT=20, MAX_RETRY=2.
// Inputs are driven and outputs sampled on the falling edge of refclk.
module tb_pll_reset_seq;

  localparam int RST_CYCLES  = 4;
  localparam int LOCK_FILTER = 8;
  localparam int TIMEOUT     = 20;
  localparam int MAX_RETRY   = 2;

  logic refclk = 1'b0;
  logic rst_n;

  pll_reset_seq_if bus();

  pll_reset_seq #(
    .RST_CYCLES (RST_CYCLES),
    .LOCK_FILTER(LOCK_FILTER),
    .TIMEOUT    (TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 50 MHz reference clock.
  always #10 refclk = ~refclk;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int         cycles;
    logic       locked;
    logic       relock;
    logic       e_pll_rst;
    logic       e_core_reset;
    logic       e_ready;
    logic       e_fail;
    logic [7:0] e_retry;
    logic [7:0] e_lost;
  } vec_t;

  vec_t vecs[32];
  int   nvec = 0;

  task automatic addVec(input int c, input logic l, input logic r,
                        input logic pr, input logic cr, input logic rd,
                        input logic f, input logic [7:0] rt, input logic [7:0] ls);
    vecs[nvec].cycles       = c;
    vecs[nvec].locked       = l;
    vecs[nvec].relock       = r;
    vecs[nvec].e_pll_rst    = pr;
    vecs[nvec].e_core_reset = cr;
    vecs[nvec].e_ready      = rd;
    vecs[nvec].e_fail       = f;
    vecs[nvec].e_retry      = rt;
    vecs[nvec].e_lost       = ls;
    nvec++;
  endtask

  task automatic tick();
    @(negedge refclk);
  endtask

  // Drive inputs for 'cycles' clocks; relock_req is only a one-cycle pulse.
  task automatic applyStimulus(input logic locked, input logic relock, input int cycles);
    bus.pll_locked = locked;
    bus.relock_req = relock;
    tick();
    bus.relock_req = 1'b0;
    for (int k = 1; k < cycles; k++) tick();
  endtask

  task automatic checkOutput(input string name, input logic pr, input logic cr,
                             input logic rd, input logic f,
                             input logic [7:0] rt, input logic [7:0] ls);
    logic [19:0] got, exp;
    got = {bus.pll_rst, bus.core_reset, bus.ready, bus.fail, bus.retry_cnt, bus.lost_cnt};
    exp = {pr, cr, rd, f, rt, ls};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got pll_rst=%b core_reset=%b ready=%b fail=%b retry=%0d lost=%0d, expected pll_rst=%b core_reset=%b ready=%b fail=%b retry=%0d lost=%0d",
               name, bus.pll_rst, bus.core_reset, bus.ready, bus.fail, bus.retry_cnt,
               bus.lost_cnt, pr, cr, rd, f, rt, ls);
    end
  endtask

  // Leaves rst_n released on a falling edge; that edge is cycle 0 of the
  // hand-computed timelines below.
  task automatic doReset();
    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    bus.relock_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Clean lock, loss in RUN, relock in RUN, two timeouts into FAIL and the
  // relock out of FAIL, all from one release of rst_n.
  task automatic buildVectors();
    addVec( 5, 1'b0, 1'b0, 1, 1, 0, 0, 8'd0, 8'd0);
    addVec( 1, 1'b0, 1'b0, 0, 1, 0, 0, 8'd0, 8'd0);
    addVec( 4, 1'b0, 1'b0, 0, 1, 0, 0, 8'd0, 8'd0);
    addVec(10, 1'b1, 1'b0, 0, 1, 0, 0, 8'd0, 8'd0);
    addVec( 1, 1'b1, 1'b0, 0, 0, 1, 0, 8'd0, 8'd0);
    addVec( 5, 1'b1, 1'b0, 0, 0, 1, 0, 8'd0, 8'd0);
    addVec( 2, 1'b0, 1'b0, 0, 0, 1, 0, 8'd0, 8'd0);
    addVec( 1, 1'b0, 1'b0, 1, 1, 0, 0, 8'd0, 8'd1);
    addVec( 3, 1'b1, 1'b0, 1, 1, 0, 0, 8'd0, 8'd1);
    addVec( 1, 1'b1, 1'b0, 0, 1, 0, 0, 8'd0, 8'd1);
    addVec( 8, 1'b1, 1'b0, 0, 1, 0, 0, 8'd0, 8'd1);
    addVec( 1, 1'b1, 1'b0, 0, 0, 1, 0, 8'd0, 8'd1);
    addVec( 1, 1'b1, 1'b1, 1, 1, 0, 0, 8'd0, 8'd1);
    addVec( 4, 1'b0, 1'b0, 0, 1, 0, 0, 8'd0, 8'd1);
    addVec(19, 1'b0, 1'b0, 0, 1, 0, 0, 8'd0, 8'd1);
    addVec( 1, 1'b0, 1'b0, 1, 1, 0, 0, 8'd1, 8'd1);
    addVec( 3, 1'b0, 1'b0, 1, 1, 0, 0, 8'd1, 8'd1);
    addVec( 1, 1'b0, 1'b0, 0, 1, 0, 0, 8'd1, 8'd1);
    addVec(19, 1'b0, 1'b0, 0, 1, 0, 0, 8'd1, 8'd1);
    addVec( 1, 1'b0, 1'b0, 0, 1, 0, 1, 8'd2, 8'd1);
    addVec(10, 1'b0, 1'b0, 0, 1, 0, 1, 8'd2, 8'd1);
    addVec( 1, 1'b0, 1'b1, 1, 1, 0, 0, 8'd0, 8'd1);
  endtask

  // Upper bound on the whole run so a stuck DUT cannot hang the bench.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] exp_lost;

    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    bus.relock_req = 1'b0;
    buildVectors();

    // Values held while rst_n is low.
    repeat (3) tick();
    checkOutput("reset_hold", 1, 1, 0, 0, 8'd0, 8'd0);

    doReset();
    for (int i = 0; i < nvec; i++) begin
      applyStimulus(vecs[i].locked, vecs[i].relock, vecs[i].cycles);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_pll_rst, vecs[i].e_core_reset,
                  vecs[i].e_ready, vecs[i].e_fail, vecs[i].e_retry, vecs[i].e_lost);
    end

    // Glitch while filtering: the filter restarts after the low sample.
    doReset();
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 2);
    checkOutput("glitch_back_to_wait", 0, 1, 0, 0, 8'd0, 8'd0);
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("glitch_no_early_run", 0, 1, 0, 0, 8'd0, 8'd0);
    applyStimulus(1'b1, 1'b0, 5);
    checkOutput("glitch_last_filter", 0, 1, 0, 0, 8'd0, 8'd0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("glitch_run", 0, 0, 1, 0, 8'd0, 8'd0);

    // Lock drop and relock request on the same edge in RUN.
    doReset();
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 11);
    checkOutput("simul_run", 0, 0, 1, 0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("simul_pre", 0, 0, 1, 0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("simul_enter", 1, 1, 0, 0, 8'd0, 8'd1);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("simul_pulse_last", 1, 1, 0, 0, 8'd0, 8'd1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("simul_pulse_end", 0, 1, 0, 0, 8'd0, 8'd1);

    // Async reset in RUN, observed before the next rising edge.
    applyStimulus(1'b1, 1'b0, 11);
    checkOutput("async_pre_run", 0, 0, 1, 0, 8'd0, 8'd1);
    @(posedge refclk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1, 1, 0, 0, 8'd0, 8'd0);

    // Repeated lock losses: lost_cnt saturates at 255.
    doReset();
    bus.pll_locked = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      n = 0;
      while (!bus.ready && n < 60) begin
        tick();
        n++;
      end
      if (!bus.ready) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL sat_wait_ready: ready=0 after %0d cycles at loss %0d, expected ready=1", n, k);
        break;
      end
      applyStimulus(1'b0, 1'b0, 3);
      exp_lost = (k > 255) ? 8'd255 : 8'(k);
      if (k == 1 || k == 254 || k == 255 || k == 256) begin
        checkOutput($sformatf("sat_loss%0d", k), 1, 1, 0, 0, 8'd0, exp_lost);
      end
      bus.pll_locked = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter RST_CYCLES, default 16, refclk cycles pll_rst is held high per reset pulse (min 1).
REQ-002 Parameter LOCK_FILTER, default 1024, consecutive refclk cycles synced lock must stay high before release (min 1).
REQ-003 Parameter TIMEOUT, default 65535, max refclk cycles in WAIT_LOCK before a retry (min 1).
REQ-004 Parameter MAX_RETRY, default 3, timeouts tolerated before FAIL (min 1, max 255).
REQ-005 refclk  in  1  sole clock, 50 MHz PLL reference; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset: asserts asynchronously, releases synchronously via 2-flop synchronizer on refclk.
REQ-007 pll_locked  in  1  PLL locked output, asynchronous to refclk.
REQ-008 relock_req  in  1  single-cycle request to re-sequence the PLL, synchronous to refclk.
REQ-009 pll_rst  out  1  active-high reset to the PLL rst input.
REQ-010 core_reset  out  1  active-high reset to the core clock domains.
REQ-011 ready  out  1  high while core clocks are valid and released.
REQ-012 fail  out  1  high while retries are exhausted.
REQ-013 retry_cnt  out  8  timeouts since last successful lock.
REQ-014 lost_cnt  out  8  lock losses in RUN, saturating at 255.

Function
REQ-015 pll_locked SHALL pass a 2-flop synchronizer (lock_s); lock_s lags pll_locked by 2 cycles.
REQ-016 FSM states SHALL be RESET_PLL, WAIT_LOCK, FILTER, RUN, FAIL; one shared down/up cycle counter, cleared on every state change.
REQ-017 RESET_PLL: pll_rst=1; after RST_CYCLES cycles in state -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0; lock_s=1 -> FILTER; else counter reaching TIMEOUT -> retry_cnt+1, then FAIL if new retry_cnt==MAX_RETRY, else RESET_PLL.
REQ-019 FILTER: lock_s=0 on any cycle -> WAIT_LOCK (timeout restarts); LOCK_FILTER consecutive lock_s=1 cycles -> RUN and retry_cnt cleared.
REQ-020 RUN: lock_s=0 -> RESET_PLL and lost_cnt+1 (saturating); relock_req=1 -> RESET_PLL.
REQ-021 RUN with lock_s=0 and relock_req=1 same cycle -> RESET_PLL, lost_cnt still incremented.
REQ-022 FAIL: pll_rst=0; holds until relock_req=1 -> RESET_PLL with retry_cnt cleared.
REQ-023 relock_req in RESET_PLL, WAIT_LOCK or FILTER -> RESET_PLL with counter restarted; retry_cnt unchanged.
REQ-024 Outputs SHALL be registered Moore decodes of the state register: core_reset=0 and ready=1 only in RUN; fail=1 only in FAIL; pll_rst=1 only in RESET_PLL.
REQ-025 First cycle of RUN is the cycle following the LOCK_FILTER-th qualifying lock_s sample; core_reset falls on that edge, no glitches on any output.
REQ-026 Counter width SHALL cover max(RST_CYCLES, LOCK_FILTER, TIMEOUT); no wrap inside any state.

Reset
REQ-027 While rst_n=0: state=RESET_PLL, pll_rst=1, core_reset=1, ready=0, fail=0, retry_cnt=0, lost_cnt=0, counter=0, synchronizer flops=0.
REQ-028 rst_n asserted mid-operation (any state) SHALL force REQ-027 values immediately, without waiting for refclk.
REQ-029 After rst_n release, full RST_CYCLES pulse SHALL be issued before WAIT_LOCK.

Verification (RST_CYCLES=4, LOCK_FILTER=8, TIMEOUT=20, MAX_RETRY=2)
REQ-030 Clean lock: release rst_n, pll_locked=1 from cycle 10 -> pll_rst high 4 cycles, core_reset falls exactly 2+8 cycles after lock edge sampled, ready=1, retry_cnt=0.
REQ-031 Timeout/fail: pll_locked held 0 -> two 4-cycle pll_rst pulses separated by 20-cycle waits, then fail=1, retry_cnt=2, core_reset=1; relock_req -> fail=0, retry_cnt=0, new pll_rst pulse.
REQ-032 Glitch in filter: lock high 5 cycles, low 1, high -> no RUN until 8 new consecutive lock_s cycles.
REQ-033 Loss in RUN: drop pll_locked -> within 3 cycles pll_rst=1, core_reset=1, ready=0, lost_cnt=1; 256 losses -> lost_cnt=255.
REQ-034 Simultaneous relock_req and lock drop in RUN -> single RESET_PLL entry, lost_cnt+1.
REQ-035 Async reset in RUN between clock edges -> core_reset=1, pll_rst=1 before next refclk edge; counters=0.
